// File: rtl/countdown_timer.sv
// countdown_timer: mm:ss down-counter clocked on clk and advanced by a 1 Hz tick enable.
// It is loaded with a preset and started or paused with a toggle.
// Expiry shows as a level `done` and a one-cycle `alarm` pulse.
// `running` and `done` decode directly from the state register.
module countdown_timer #(
   parameter int MAX_MIN = 59
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       load,
   input  logic [5:0] load_min,
   input  logic [5:0] load_sec,
   input  logic       start,
   output logic [5:0] min,
   output logic [5:0] sec,
   output logic       running,
   output logic       done,
   output logic       alarm
);

   localparam logic [5:0] MAX_MIN_V = 6'(MAX_MIN);
   localparam logic [5:0] MAX_SEC_V = 6'd59;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [5:0] min_q, min_d;
   logic [5:0] sec_q, sec_d;
   logic       alarm_q, alarm_d;

   // Decremented count, used only when a tick is applied in RUN
   logic [5:0] dec_min, dec_sec;
   logic       count_zero;

   // One-second decrement with a borrow from minutes; zero is checked first so nothing underflows
   always_comb begin
      dec_min = min_q;
      dec_sec = sec_q;
      if (sec_q != 6'd0) begin
         dec_sec = sec_q - 6'd1;
      end else if (min_q != 6'd0) begin
         dec_min = min_q - 6'd1;
         dec_sec = MAX_SEC_V;
      end
      count_zero = (min_q == 6'd0) && (sec_q == 6'd0);
   end

   // Next state and next count, with event priority load > start > tick
   always_comb begin
      state_d = state_q;
      min_d   = min_q;
      sec_d   = sec_q;
      alarm_d = 1'b0;
      if (load) begin
         min_d   = (load_min > MAX_MIN_V) ? MAX_MIN_V : load_min;
         sec_d   = (load_sec > MAX_SEC_V) ? MAX_SEC_V : load_sec;
         state_d = IDLE;
      end else if (start) begin
         unique case (state_q)
            IDLE, PAUSED: begin
               if (!count_zero) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               state_d = PAUSED;
            end
            DONE: begin
               state_d = IDLE;
               min_d   = 6'd0;
               sec_d   = 6'd0;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end else if (tick && (state_q == RUN)) begin
         min_d = dec_min;
         sec_d = dec_sec;
         if ((dec_min == 6'd0) && (dec_sec == 6'd0)) begin
            state_d = DONE;
            alarm_d = 1'b1;
         end
      end
   end

   // State, count and alarm registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         min_q   <= 6'd0;
         sec_q   <= 6'd0;
         alarm_q <= 1'b0;
      end else begin
         state_q <= state_d;
         min_q   <= min_d;
         sec_q   <= sec_d;
         alarm_q <= alarm_d;
      end
   end

   assign min     = min_q;
   assign sec     = sec_q;
   assign running = (state_q == RUN);
   assign done    = (state_q == DONE);
   assign alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: drives directed and random events into countdown_timer.
// A seconds-based reference model predicts every cycle's outputs.
module tb_countdown_timer;

   localparam int MAX_MIN = 59;
   localparam int W       = 15;  // {min[5:0], sec[5:0], running, done, alarm}

   logic       clk;
   logic       reset;
   logic       tick;
   logic       load;
   logic [5:0] load_min;
   logic [5:0] load_sec;
   logic       start;
   logic [5:0] min;
   logic [5:0] sec;
   logic       running;
   logic       done;
   logic       alarm;

   int errors = 0;
   int checks = 0;

   logic [W-1:0] exp_q[$];

   // Reference model: remaining time in whole seconds plus mode flags
   int m_total   = 0;
   bit m_run     = 0;
   bit m_paused  = 0;
   bit m_done    = 0;
   bit m_alarm   = 0;

   countdown_timer #(.MAX_MIN(MAX_MIN)) dut (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .load     (load),
      .load_min (load_min),
      .load_sec (load_sec),
      .start    (start),
      .min      (min),
      .sec      (sec),
      .running  (running),
      .done     (done),
      .alarm    (alarm)
   );

   // Clock and reset defaults
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      reset    = 1'b1;
      tick     = 1'b0;
      load     = 1'b0;
      load_min = 6'd0;
      load_sec = 6'd0;
      start    = 1'b0;
   end

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic void model_step(input bit rst, input bit ld, input int lm, input int ls,
                                      input bit st, input bit tk);
      m_alarm = 0;
      if (rst) begin
         m_total = 0; m_run = 0; m_paused = 0; m_done = 0;
      end else if (ld) begin
         m_total = imin(lm, MAX_MIN) * 60 + imin(ls, 59);
         m_run = 0; m_paused = 0; m_done = 0;
      end else if (st) begin
         if (m_done) begin
            m_total = 0; m_done = 0;
         end else if (m_run) begin
            m_run = 0; m_paused = 1;
         end else if (m_total > 0) begin
            m_run = 1; m_paused = 0;
         end
      end else if (tk && m_run) begin
         if (m_total > 0) m_total = m_total - 1;
         if (m_total == 0) begin
            m_run = 0; m_done = 1; m_alarm = 1;
         end
      end
   endfunction

   function automatic logic [W-1:0] model_expect();
      logic [5:0] em, es;
      em = 6'(m_total / 60);
      es = 6'(m_total % 60);
      return {em, es, m_run, m_done, m_alarm};
   endfunction

   // Driver: apply one cycle of inputs on the falling edge and queue the predicted outputs
   task automatic cyc(input bit rst, input bit ld, input int lm, input int ls,
                      input bit st, input bit tk);
      @(negedge clk);
      reset    = rst;
      load     = ld;
      load_min = 6'(lm);
      load_sec = 6'(ls);
      start    = st;
      tick     = tk;
      model_step(rst, ld, lm, ls, st, tk);
      exp_q.push_back(model_expect());
   endtask

   task automatic idle(input int n, input bit tk);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, tk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 1);
   endtask

   task automatic do_load(input int lm, input int ls);
      cyc(0, 1, lm, ls, 0, 0);
   endtask

   task automatic do_start();
      cyc(0, 0, 0, 0, 1, 0);
   endtask

   // Monitor: after each rising edge compare the registered outputs with the oldest prediction
   always @(posedge clk) begin
      logic [W-1:0] got, exp;
      #1;
      if (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         got = {min, sec, running, done, alarm};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL outputs t=%0t got min=%0d sec=%0d run=%0b done=%0b alarm=%0b exp min=%0d sec=%0d run=%0b done=%0b alarm=%0b",
                     $time, got[14:9], got[8:3], got[2], got[1], got[0],
                     exp[14:9], exp[8:3], exp[2], exp[1], exp[0]);
         end
      end
   end

   // Stimulus sequence, then drain and report
   initial begin
      int lm, ls, r;
      bit ld, st, tk, rs;

      // Reset, then idle with ticks present
      cyc(1, 0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0, 0);
      idle(10, 1);

      // 01:02 counted fully down with back-to-back ticks, then extra ticks at 00:00
      do_load(1, 2);
      do_start();
      ticks(62);
      ticks(3);
      idle(2, 0);

      // Pause and resume
      do_load(0, 5);
      do_start();
      ticks(2);
      do_start();
      ticks(3);
      do_start();
      ticks(3);
      idle(2, 0);

      // Clamping, and start on 00:00 ignored
      do_load(63, 60);
      idle(2, 1);
      do_load(0, 0);
      do_start();
      idle(3, 1);

      // Load + start + tick in RUN at 00:10
      do_load(0, 12);
      do_start();
      ticks(2);
      cyc(0, 1, 0, 30, 1, 1);
      idle(2, 1);
      // start + tick together in RUN
      do_start();
      ticks(2);
      cyc(0, 0, 0, 0, 1, 1);
      idle(3, 1);

      // Reset with tick while RUN at 02:00
      do_load(2, 0);
      do_start();
      cyc(1, 0, 0, 0, 0, 1);
      idle(2, 1);

      // DONE then start returns to IDLE with 00:00
      do_load(0, 2);
      do_start();
      ticks(2);
      idle(2, 1);
      do_start();
      idle(2, 1);

      // Random phase
      for (int i = 0; i < 600; i++) begin
         r  = $urandom_range(0, 99);
         rs = (r == 0);
         ld = ($urandom_range(0, 29) == 0);
         st = ($urandom_range(0, 9) == 0);
         tk = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 3) == 0) begin
            lm = $urandom_range(0, 63);
            ls = $urandom_range(0, 63);
         end else begin
            lm = $urandom_range(0, 1);
            ls = $urandom_range(0, 20);
         end
         cyc(rs, ld, lm, ls, st, tk);
      end
      idle(2, 0);

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got pending=%0d exp pending=0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
